// File: rtl/pe_pack_if.sv
// Handshake bundle between the PE controller (pixel source / word sink) and the
// output packer: pixel stream in, packed words with write address out.
interface pe_pack_if #(
  parameter int binary_output_levels = 2,
  parameter int simd_width           = 32,
  parameter int input_address        = 12
);
  logic                                       in_valid;
  logic [binary_output_levels-1:0]            in_bits;
  logic                                       in_ready;
  logic                                       flush;
  logic                                       out_valid;
  logic                                       out_ready;
  logic [simd_width*binary_output_levels-1:0] out_data;
  logic [input_address-1:0]                   out_addr;
  logic                                       frame_done;

  modport master (
    output in_valid, in_bits, flush, out_ready,
    input  in_ready, out_valid, out_data, out_addr, frame_done
  );

  modport slave (
    input  in_valid, in_bits, flush, out_ready,
    output in_ready, out_valid, out_data, out_addr, frame_done
  );
endinterface

// File: rtl/pe_output_packer.sv
// Packs binarized PE output pixels level-major into Input_Buffer words and
// emits them with a wrapping write address and an end-of-frame pulse.
module pe_output_packer #(
  parameter int binary_output_levels = 2,
  parameter int simd_width           = 32,
  parameter int input_address        = 12,
  parameter int frame_words          = 18
) (
  input  logic     clk,
  input  logic     rst,
  pe_pack_if.slave bus
);

  localparam int LANE_W = (simd_width > 1) ? $clog2(simd_width) : 1;
  localparam int WORD_W = simd_width * binary_output_levels;

  localparam logic [LANE_W-1:0]        LAST_LANE = LANE_W'(simd_width - 1);
  localparam logic [input_address-1:0] LAST_ADDR = input_address'(frame_words - 1);

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

  slot_state_t              slot_state_q, slot_state_d;
  logic [LANE_W-1:0]        lane_cnt_q, lane_cnt_d;
  logic [WORD_W-1:0]        pack_q, pack_d;
  logic [WORD_W-1:0]        out_data_q, out_data_d;
  logic [input_address-1:0] addr_q, addr_d;
  logic                     frame_done_q, frame_done_d;

  logic              slot_free;
  logic              last_lane;
  logic              accept;
  logic              complete;
  logic              flush_fire;
  logic              load;
  logic              handshake;
  logic [WORD_W-1:0] pack_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_state_q <= SLOT_EMPTY;
      lane_cnt_q   <= '0;
      pack_q       <= '0;
      out_data_q   <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      slot_state_q <= slot_state_d;
      lane_cnt_q   <= lane_cnt_d;
      pack_q       <= pack_d;
      out_data_q   <= out_data_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    slot_state_d = slot_state_q;
    lane_cnt_d   = lane_cnt_q;
    pack_d       = pack_q;
    out_data_d   = out_data_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;

    // Only the final lane needs a free slot; earlier lanes keep flowing while
    // the previous word waits downstream.
    slot_free = (slot_state_q == SLOT_EMPTY) || bus.out_ready;
    last_lane = (lane_cnt_q == LAST_LANE);
    accept    = bus.in_valid && (slot_free || !last_lane);
    complete  = accept && last_lane;
    handshake = (slot_state_q == SLOT_FULL) && bus.out_ready;

    pack_acc = pack_q;
    if (accept) begin
      for (int l = 0; l < binary_output_levels; l++) begin
        pack_acc[simd_width*l + int'(lane_cnt_q)] = bus.in_bits[l];
      end
    end

    // Lanes fill in order, so occupancy is tracked by lane_cnt, not pack contents.
    flush_fire = bus.flush && slot_free && ((lane_cnt_q != '0) || accept);
    load       = complete || flush_fire;

    if (handshake) begin
      addr_d       = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
      frame_done_d = (addr_q == LAST_ADDR);
    end

    if (load) begin
      slot_state_d = SLOT_FULL;
      out_data_d   = pack_acc;
      pack_d       = '0;
      lane_cnt_d   = '0;
    end else begin
      pack_d = pack_acc;
      if (accept) lane_cnt_d = lane_cnt_q + 1'b1;
      if (handshake) slot_state_d = SLOT_EMPTY;
    end

    bus.in_ready   = slot_free || !last_lane;
    bus.out_valid  = (slot_state_q == SLOT_FULL);
    bus.out_data   = out_data_q;
    bus.out_addr   = addr_q;
    bus.frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_pe_output_packer.sv
// Randomized and directed bench for pe_output_packer against a queue-based
// model of pixel packing, slot occupancy and address sequencing.
module tb_pe_output_packer;

  localparam int S  = 4;
  localparam int L  = 2;
  localparam int AW = 4;
  localparam int F  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pe_pack_if #(.binary_output_levels(L), .simd_width(S), .input_address(AW)) bus ();

  pe_output_packer #(
    .binary_output_levels(L),
    .simd_width(S),
    .input_address(AW),
    .frame_words(F)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [L-1:0]   m_pix[$];
  bit             m_full;
  logic [S*L-1:0] m_data;
  int             m_addr;
  bit             m_fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [S*L-1:0] build_word();
    logic [S*L-1:0] w = '0;
    foreach (m_pix[i])
      for (int l = 0; l < L; l++) w[S*l + i] = m_pix[i][l];
    return w;
  endfunction

  task automatic model_reset();
    m_pix.delete();
    m_full = 0;
    m_data = '0;
    m_addr = 0;
    m_fd   = 0;
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model,
  // and return 1 ns after the rising edge.
  task automatic step(input bit v, input logic [L-1:0] b, input bit fl, input bit ordy);
    bit free, rdy, acc, hs, load;
    bus.in_valid  = v;
    bus.in_bits   = b;
    bus.flush     = fl;
    bus.out_ready = ordy;
    @(negedge clk);
    free = !m_full || ordy;
    rdy  = free || (m_pix.size() < S-1);
    chk("out_valid", bus.out_valid, m_full);
    if (m_full) chk("out_data", bus.out_data, m_data);
    chk("out_addr", bus.out_addr, m_addr);
    chk("in_ready", bus.in_ready, rdy);
    chk("frame_done", bus.frame_done, m_fd);
    acc = v && rdy;
    hs  = m_full && ordy;
    if (acc) m_pix.push_back(b);
    load = (m_pix.size() == S) || (fl && free && m_pix.size() > 0);
    m_fd = hs && (m_addr == F-1);
    if (hs) m_addr = (m_addr + 1) % F;
    if (load) begin
      m_data = build_word();
      m_pix.delete();
      m_full = 1;
    end else if (hs) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_addr", bus.out_addr, '0);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    do_reset();

    // basic word: lanes 0..3 = 01,10,11,00
    step(1, 2'b01, 0, 1);
    step(1, 2'b10, 0, 1);
    step(1, 2'b11, 0, 1);
    step(1, 2'b00, 0, 1);
    chk("t1_valid", bus.out_valid, 1'b1);
    chk("t1_word", bus.out_data, 8'b0110_0101);
    chk("t1_addr", bus.out_addr, 4'd0);
    drain();

    // backpressure: 8 pixels into a blocked slot, then release
    for (int i = 0; i < 8; i++) step(1, 2'(i), 0, 0);
    chk("t2_stall", bus.in_ready, 1'b0);
    for (int i = 0; i < 4; i++) step(1, 2'b11, 0, 1);
    drain();

    // full frame plus one: address wrap and frame_done
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 2'($urandom_range(0, 3)), 0, 1);
    drain();

    // flush of a partial word, then flush with nothing pending
    step(1, 2'b11, 0, 1);
    step(1, 2'b11, 1, 1);
    chk("t4_word", bus.out_data, 8'b0011_0011);
    chk("t4_valid", bus.out_valid, 1'b1);
    step(0, '0, 1, 1);
    chk("t4_empty_flush", bus.out_valid, 1'b0);

    // flush coinciding with the 3rd pixel
    step(1, 2'b11, 0, 1);
    step(1, 2'b11, 0, 1);
    step(1, 2'b11, 1, 1);
    chk("t5_word", bus.out_data, 8'b0111_0111);
    drain();

    // reset in the middle of a word
    step(1, 2'b11, 0, 1);
    step(1, 2'b11, 0, 1);
    do_reset();
    step(1, 2'b10, 0, 1);
    step(1, 2'b10, 0, 1);
    step(1, 2'b01, 0, 1);
    step(1, 2'b01, 0, 1);
    chk("t6_word", bus.out_data, 8'b0011_1100);
    chk("t6_addr", bus.out_addr, 4'd0);
    drain();

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
